store_buffer: RTL



---
 rtl/store_buffer.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/store_buffer.sv
// Store buffer: queues committed stores in program order and drains them to the d-cache write port.
// Optional TL-stage load forwarding is enabled by defining STORE_BUFFER_FWD_EN.
module store_buffer #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 20,
    parameter int DATA_W = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     store_en,
    input  logic                     store_isbyte,
    input  logic [ADDR_W-1:0]        store_addr,
    input  logic [DATA_W-1:0]        store_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic                     drain_valid,
    output logic [ADDR_W-1:0]        drain_addr,
    output logic [DATA_W-1:0]        drain_data,
    output logic                     drain_isbyte,
    input  logic                     drain_ready,
    input  logic [ADDR_W-1:0]        lookup_addr,
    input  logic                     lookup_isbyte,
    output logic                     lookup_hit,
    output logic [DATA_W-1:0]        lookup_data,
    output logic                     lookup_stall
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [ADDR_W-1:0] addr_q [DEPTH];
    logic [ADDR_W-1:0] addr_d [DEPTH];
    logic [DATA_W-1:0] data_q [DEPTH];
    logic [DATA_W-1:0] data_d [DEPTH];
    logic [DEPTH-1:0]  isbyte_q, isbyte_d;
    logic [DEPTH-1:0]  valid_q, valid_d;
    logic [PW-1:0]     head_q, head_d;
    logic [PW-1:0]     tail_q, tail_d;
    logic [CW-1:0]     count_q, count_d;
    logic              overflow_q, overflow_d;
    logic              push, pop;

    always_comb begin
        addr_d     = addr_q;
        data_d     = data_q;
        isbyte_d   = isbyte_q;
        valid_d    = valid_q;
        head_d     = head_q;
        tail_d     = tail_q;
        count_d    = count_q;
        pop        = valid_q[head_q] && drain_ready;
        // A full buffer still accepts a store when the head leaves in the same cycle.
        push       = store_en && ((count_q < CW'(DEPTH)) || pop);
        overflow_d = overflow_q || (store_en && !push);

        if (pop) begin
            valid_d[head_q] = 1'b0;
            head_d          = head_q + PW'(1);
        end
        if (push) begin
            addr_d[tail_q]   = store_addr;
            data_d[tail_q]   = store_data;
            isbyte_d[tail_q] = store_isbyte;
            valid_d[tail_q]  = 1'b1;
            tail_d           = tail_q + PW'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                addr_q[i] <= '0;
                data_q[i] <= '0;
            end
            isbyte_q   <= '0;
            valid_q    <= '0;
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            addr_q     <= addr_d;
            data_q     <= data_d;
            isbyte_q   <= isbyte_d;
            valid_q    <= valid_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    assign count        = count_q;
    assign full         = (count_q == CW'(DEPTH));
    assign empty        = (count_q == '0);
    assign overflow     = overflow_q;
    assign drain_valid  = valid_q[head_q];
    assign drain_addr   = addr_q[head_q];
    assign drain_data   = data_q[head_q];
    assign drain_isbyte = isbyte_q[head_q];

`ifdef STORE_BUFFER_FWD_EN
    logic [PW-1:0] scan_idx, fwd_idx;
    logic          fwd_found;

    always_comb begin
        scan_idx     = head_q;
        fwd_idx      = head_q;
        fwd_found    = 1'b0;
        lookup_hit   = 1'b0;
        lookup_stall = 1'b0;
        lookup_data  = '0;
        // Scan oldest to youngest so the last match seen is the one nearest the tail.
        for (int i = 0; i < DEPTH; i++) begin
            scan_idx = head_q + PW'(i);
            if (valid_q[scan_idx] &&
                addr_q[scan_idx][ADDR_W-1:2] == lookup_addr[ADDR_W-1:2]) begin
                fwd_found = 1'b1;
                fwd_idx   = scan_idx;
            end
        end
        if (fwd_found) begin
            if (!isbyte_q[fwd_idx]) begin
                lookup_hit = 1'b1;
                if (lookup_isbyte)
                    lookup_data = DATA_W'(data_q[fwd_idx][{lookup_addr[1:0], 3'b000} +: 8]);
                else
                    lookup_data = data_q[fwd_idx];
            end else if (lookup_isbyte && addr_q[fwd_idx][1:0] == lookup_addr[1:0]) begin
                lookup_hit  = 1'b1;
                lookup_data = DATA_W'(data_q[fwd_idx][7:0]);
            end else begin
                lookup_stall = 1'b1;
            end
        end
    end
`else
    logic unused_lookup;
    assign unused_lookup = ^{lookup_addr, lookup_isbyte};
    assign lookup_hit    = 1'b0;
    assign lookup_stall  = 1'b0;
    assign lookup_data   = '0;
`endif

endmodule
